serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction a - b.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend, sampled only on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend, sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit, high while bit-serial processing is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port diff, output, WIDTH bits, the registered difference (a - b - bin) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit, the registered final borrow, high when a < b + bin.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL be accepted: load a_sr=a, b_sr=b, borrow register br=bin (0 unless the REQ-025 macro is defined), bit counter=0, then enter SHIFT.
REQ-013 Each SHIFT cycle SHALL compute one full-subtractor bit: d = a_sr[0]^b_sr[0]^br and bnext = (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & br).
REQ-014 At each SHIFT edge, a_sr and b_sr SHALL shift right, d SHALL enter the result shift register at its MSB, br SHALL take bnext, and the counter SHALL increment.
REQ-015 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE and load diff from the completed result register and borrow_out from the final bnext on that same edge.
REQ-016 Latency: done SHALL be high in the cycle that begins WIDTH edges after the edge that accepted start; for WIDTH=1 this is the next cycle.
REQ-017 done SHALL be high only in DONE and low in every other state.
REQ-018 busy SHALL be high only in SHIFT and low in every other state.
REQ-019 From DONE, the FSM SHALL go to SHIFT if start=1, otherwise to IDLE; back-to-back operations SHALL lose no cycle.
REQ-020 start during SHIFT SHALL be ignored; no queuing, and the operands in flight SHALL be unaffected.
REQ-021 diff and borrow_out SHALL hold their last values until the next DONE entry or reset; they SHALL NOT change during SHIFT.
REQ-022 Changes on a or b outside the accepting edge SHALL have no effect.

Reset
REQ-023 rst=1 at an edge SHALL force the IDLE state, set busy=0, done=0, diff=0 and borrow_out=0, and clear all shift registers, br and the counter; rst SHALL take priority over start.
REQ-024 Reset asserted during SHIFT SHALL abort the operation with no done pulse and no partial result on diff.

Configuration
REQ-025 With macro SERIAL_SUBTRACTOR_BORROW_IN_EN defined, the block SHALL add an input port bin (1 bit, placed after b) that is sampled on the accepting edge as the initial borrow, so the result is a - b - bin.
REQ-026 Without SERIAL_SUBTRACTOR_BORROW_IN_EN defined, the bin port SHALL NOT exist and the initial borrow SHALL be constant 0.

Verification
REQ-027 The bench SHALL cover: WIDTH=8, a=0x5A, b=0x3C, one-cycle start -> busy for 8 cycles, then done pulse, diff=0x1E, borrow_out=0.
REQ-028 The bench SHALL cover: a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; and a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
REQ-029 The bench SHALL cover: start held high with a=0x05, b=0x03, then a/b changed to 0x00/0x7F during SHIFT -> result diff=0x02 only, start ignored while busy, next operation begins in the DONE cycle, and the second result is 0x81 with borrow_out=1.
REQ-030 The bench SHALL cover: rst pulsed in the 4th SHIFT cycle -> no done, diff=0x00, borrow_out=0, busy=0 on the next cycle, and a new start afterwards computes correctly.
REQ-031 The bench SHALL cover: with the macro defined, a=0x10, b=0x0F, bin=1 -> diff=0x00, borrow_out=0; and a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow_out=1.
REQ-032 The bench SHALL cover: WIDTH=1, a=0, b=1 -> done in the cycle after acceptance, diff=1, borrow_out=1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Bus bundle for serial_subtractor: start/operands in, status/result out.
// The bin signal exists only when SERIAL_SUBTRACTOR_BORROW_IN_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    logic             bin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    modport slave  (input  start, a, b, bin, output busy, done, diff, borrow_out);
    modport master (output start, a, b, bin, input  busy, done, diff, borrow_out);
`else
    modport slave  (input  start, a, b, output busy, done, diff, borrow_out);
    modport master (output start, a, b, input  busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH one bit per clock,
// LSB first, and reports the final borrow.
// Optional feature macro: SERIAL_SUBTRACTOR_BORROW_IN_EN adds a borrow-in (bin)
// sampled with the operands; without it the initial borrow is 0.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// SHIFT | one full-subtractor bit per cycle, busy high
// DONE  | result just loaded, done pulses; start here chains with no gap
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_last;
    logic             w_bin;
    logic             w_d;
    logic             w_bnext;
    logic [WIDTH-1:0] w_res_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
    assign w_bin = bus.bin;
`else
    assign w_bin = 1'b0;
`endif

    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_d     = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_bnext = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);

    // The new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_d;
        end else begin : g_res_wn
            assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow, counter and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res        <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= bus.a;
            r_b_sr <= bus.b;
            r_res  <= '0;
            r_br   <= w_bin;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_res  <= w_res_nxt;
            r_br   <= w_bnext;
            if (w_last) begin
                r_cnt        <= '0;
                r_diff       <= w_res_nxt;
                r_borrow_out <= w_bnext;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule
